// File: rtl/fp_double.sv
// Shared IEEE-754 binary64 helpers and the state encoding of the g' row-mean block.
package fp_double;

  typedef logic [63:0] double_t;

  localparam double_t DOUBLE_ZERO = 64'h0000000000000000;
  localparam double_t DOUBLE_ONE  = 64'h3FF0000000000000;

  typedef enum logic [2:0] {
    GPM_IDLE,
    GPM_LOAD,
    GPM_ISSUE,
    GPM_WAIT,
    GPM_SCALE,
    GPM_DONE
  } gpm_state_e;

  // Behavioural product; the FPGA flow maps this onto the vendor multiplier core.
  function automatic double_t mul_double(input double_t a, input double_t b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic isnan_double(input double_t a);
    return (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
  endfunction

endpackage

// File: rtl/double_add_seq.sv
// ADD_LAT-stage pipelined double adder; the sum is a behavioural stand-in for the vendor FP-add core.
module double_add_seq
  import fp_double::*;
#(
  parameter int ADD_LAT = 7
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  double_t a,
  input  double_t b,
  output logic    out_valid,
  output double_t result
);

  logic [ADD_LAT-1:0] vld_q;
  double_t            res_q [ADD_LAT];
  double_t            sum;

  assign sum = $realtobits($bitstoreal(a) + $bitstoreal(b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < ADD_LAT; k++) res_q[k] <= DOUBLE_ZERO;
    end else begin
      vld_q[0] <= in_valid;
      res_q[0] <= sum;
      for (int k = 1; k < ADD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[ADD_LAT-1];
  assign result    = res_q[ADD_LAT-1];

endmodule

// File: rtl/fun_g_prime_mean.sv
// Per-row sample mean of the g' matrix: element-serial accumulation through one shared
// pipelined adder, then a scale by 1/SIZE_B.
module fun_g_prime_mean
  import fp_double::*;
#(
  parameter int      SIZE_A  = 8,
  parameter int      SIZE_B  = 8,
  parameter int      ADD_LAT = 7,
  parameter double_t INV_B   = 64'h3FC0000000000000
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  double_t mat      [SIZE_A][SIZE_B],
  output double_t mean_out [SIZE_A],
  output logic    busy,
  output logic    valid,
  output logic    nan_flag
);

  localparam int AW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int BW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam int WW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(SIZE_A - 1);
  localparam logic [BW-1:0] LAST_B = BW'(SIZE_B - 1);

  gpm_state_e    state_q;
  double_t       mat_q   [SIZE_A][SIZE_B];
  double_t       mean_q  [SIZE_A];
  double_t       acc_q;
  logic [AW-1:0] rowIdx_q;
  logic [BW-1:0] colIdx_q;
  logic [WW-1:0] wcnt_q;
  logic          busy_q;
  logic          valid_q;
  logic          nan_q;

  logic    addInValid;
  logic    addOutValid;
  double_t addResult;

  assign addInValid = (state_q == GPM_ISSUE);

  double_add_seq #(.ADD_LAT(ADD_LAT)) u_add (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (addInValid),
    .a         (acc_q),
    .b         (mat_q[rowIdx_q][colIdx_q]),
    .out_valid (addOutValid),
    .result    (addResult)
  );

  // The accumulator is only updated from the adder's out_valid; wcnt just guards against early results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GPM_IDLE;
      acc_q    <= DOUBLE_ZERO;
      rowIdx_q <= '0;
      colIdx_q <= '0;
      wcnt_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      nan_q    <= 1'b0;
      for (int i = 0; i < SIZE_A; i++) begin
        mean_q[i] <= DOUBLE_ZERO;
        for (int j = 0; j < SIZE_B; j++) mat_q[i][j] <= DOUBLE_ZERO;
      end
    end else begin
      case (state_q)
        GPM_IDLE, GPM_DONE: begin
          if (start) begin
            mat_q   <= mat;
            valid_q <= 1'b0;
            nan_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= GPM_LOAD;
          end
        end
        GPM_LOAD: begin
          rowIdx_q <= '0;
          colIdx_q <= '0;
          acc_q    <= DOUBLE_ZERO;
          state_q  <= GPM_ISSUE;
        end
        GPM_ISSUE: begin
          wcnt_q  <= WW'(ADD_LAT - 1);
          state_q <= GPM_WAIT;
        end
        GPM_WAIT: begin
          if (wcnt_q != '0) wcnt_q <= wcnt_q - WW'(1);
          if (addOutValid) begin
            assert (wcnt_q == '0);
            acc_q <= addResult;
            nan_q <= nan_q | isnan_double(addResult);
            if (colIdx_q == LAST_B) begin
              state_q <= GPM_SCALE;
            end else begin
              colIdx_q <= colIdx_q + BW'(1);
              state_q  <= GPM_ISSUE;
            end
          end
        end
        GPM_SCALE: begin
          mean_q[rowIdx_q] <= mul_double(acc_q, INV_B);
          if (rowIdx_q == LAST_A) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= GPM_DONE;
          end else begin
            rowIdx_q <= rowIdx_q + AW'(1);
            colIdx_q <= '0;
            acc_q    <= DOUBLE_ZERO;
            state_q  <= GPM_ISSUE;
          end
        end
        default: state_q <= GPM_IDLE;
      endcase
    end
  end

  assign mean_out = mean_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign nan_flag = nan_q;

endmodule

// File: tb/tb_fun_g_prime_mean.sv
// Self-checking bench for fun_g_prime_mean: directed and random matrices against a
// real-arithmetic row-mean model, plus handshake, latency and reset cases.
module tb_fun_g_prime_mean;

  localparam int SIZE_A  = 8;
  localparam int SIZE_B  = 8;
  localparam int ADD_LAT = 7;
  localparam int EXP_LAT = 1 + SIZE_A * (SIZE_B * (ADD_LAT + 1) + 1);
  localparam int BUDGET  = 3 * EXP_LAT;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] mat     [SIZE_A][SIZE_B];
  logic [63:0] meanOut [SIZE_A];
  logic        busy;
  logic        valid;
  logic        nanFlag;

  logic [63:0] expMean [SIZE_A];
  bit          expNan;
  int          checks = 0;
  int          errors = 0;
  int          cycles;

  fun_g_prime_mean #(
    .SIZE_A  (SIZE_A),
    .SIZE_B  (SIZE_B),
    .ADD_LAT (ADD_LAT),
    .INV_B   (64'h3FC0000000000000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mat      (mat),
    .mean_out (meanOut),
    .busy     (busy),
    .valid    (valid),
    .nan_flag (nanFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isNan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'h0);
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Row mean as the arithmetic says: sum left to right in double precision, then divide by the sample count.
  task automatic computeExpected();
    expNan = 1'b0;
    for (int i = 0; i < SIZE_A; i++) begin
      real acc;
      acc = 0.0;
      for (int j = 0; j < SIZE_B; j++) begin
        acc = acc + $bitstoreal(mat[i][j]);
        if (isNan(mat[i][j])) expNan = 1'b1;
      end
      expMean[i] = $realtobits(acc / real'(SIZE_B));
      if (isNan(expMean[i])) expNan = 1'b1;
    end
  endtask

  task automatic fillConst(input logic [63:0] v);
    for (int i = 0; i < SIZE_A; i++)
      for (int j = 0; j < SIZE_B; j++) mat[i][j] = v;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < SIZE_A; i++)
      for (int j = 0; j < SIZE_B; j++)
        mat[i][j] = $realtobits((real'($urandom_range(2000000, 0)) - 1000000.0) /
                                real'($urandom_range(997, 1)));
  endtask

  // Snapshot the expectation, then pulse start; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input string tag);
    computeExpected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEq({tag, " busy after accept"}, 64'(busy), 64'd1);
    checkEq({tag, " valid after accept"}, 64'(valid), 64'd0);
  endtask

  task automatic waitValid(input int from, output int n);
    n = from;
    while (!valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < SIZE_A; i++) begin
      if (isNan(expMean[i]))
        checkEq($sformatf("%s mean[%0d] isNaN", tag, i), 64'(isNan(meanOut[i])), 64'd1);
      else
        checkEq($sformatf("%s mean[%0d]", tag, i), meanOut[i], expMean[i]);
    end
    checkEq({tag, " valid"}, 64'(valid), 64'd1);
    checkEq({tag, " busy done"}, 64'(busy), 64'd0);
    checkEq({tag, " nan_flag"}, 64'(nanFlag), 64'(expNan));
  endtask

  task automatic runAndCheck(input string tag);
    applyStimulus(tag);
    waitValid(0, cycles);
    checkEq({tag, " latency"}, 64'(cycles), 64'(EXP_LAT));
    checkOutput(tag);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fillConst(64'h0);
    repeat (2) @(negedge clk);
    checkEq("reset busy", 64'(busy), 64'd0);
    checkEq("reset valid", 64'(valid), 64'd0);
    checkEq("reset nan_flag", 64'(nanFlag), 64'd0);
    for (int i = 0; i < SIZE_A; i++) checkEq($sformatf("reset mean[%0d]", i), meanOut[i], 64'h0);
    rst = 1'b0;

    fillConst(64'h3FF0000000000000);
    runAndCheck("ones");
    checkEq("ones literal", meanOut[0], 64'h3FF0000000000000);

    for (int i = 0; i < SIZE_A; i++)
      for (int j = 0; j < SIZE_B; j++) mat[i][j] = $realtobits(real'(j));
    runAndCheck("ramp");
    checkEq("ramp literal", meanOut[7], 64'h400C000000000000);

    fillConst(64'hBFE0000000000000);
    for (int j = 0; j < SIZE_B; j++) mat[3][j] = 64'h4000000000000000;
    runAndCheck("halves");
    checkEq("halves row0 literal", meanOut[0], 64'hBFE0000000000000);
    checkEq("halves row3 literal", meanOut[3], 64'h4000000000000000);

    fillConst(64'h3FF0000000000000);
    mat[5][2] = 64'h7FF8000000000000;
    runAndCheck("nan");

    // A start mid-run (with new data on mat) must change nothing.
    fillRandom();
    applyStimulus("ignore");
    repeat (99) @(negedge clk);
    start = 1'b1;
    fillRandom();
    @(negedge clk);
    start = 1'b0;
    checkEq("ignore busy mid-run", 64'(busy), 64'd1);
    checkEq("ignore valid mid-run", 64'(valid), 64'd0);
    waitValid(100, cycles);
    checkEq("ignore latency", 64'(cycles), 64'(EXP_LAT));
    checkOutput("ignore");

    fillRandom();
    runAndCheck("restart");

    // Asynchronous reset partway through a run.
    fillRandom();
    applyStimulus("abort");
    repeat (200) @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("abort busy", 64'(busy), 64'd0);
    checkEq("abort valid", 64'(valid), 64'd0);
    checkEq("abort nan_flag", 64'(nanFlag), 64'd0);
    for (int i = 0; i < SIZE_A; i++) checkEq($sformatf("abort mean[%0d]", i), meanOut[i], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    fillConst(64'h3FF0000000000000);
    runAndCheck("post-reset");

    for (int r = 0; r < 3; r++) begin
      fillRandom();
      runAndCheck($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fun_g_prime_mean.md
Name: fun_g_prime_mean

Overview:
- Downstream of the elementwise g'(u) = (1-u^2)·exp(-u^2/2) stage in the FastICA fixed-point update.
- Consumes the SIZE_A×SIZE_B double matrix of g' values and produces the per-row sample mean E{g'(wᵀx)}, one double per row.
- Feeds the weight-update stage that forms E{x·g(wᵀx)} − E{g'(wᵀx)}·w.
- Element-serial: one pipelined double adder is reused, and the accumulator is resolved before each next add.

Parameters:
- SIZE_A, 8, number of rows (independent components).
- SIZE_B, 8, number of columns (samples averaged per row).
- ADD_LAT, 7, latency in cycles of the double adder sub-module (≥1).
- INV_B, 64'h3FC0000000000000, IEEE-754 double of 1/SIZE_B. The default is 0.125; the integrator sets it to match SIZE_B.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- mat  in  double[SIZE_A][SIZE_B]  g' matrix. Captured on the accepted start.
- mean_out  out  double[SIZE_A]  per-row mean. Held until the next accepted start.
- busy  out  1  high from the cycle after start acceptance until valid rises.
- valid  out  1  level: high while mean_out holds a completed result.
- nan_flag  out  1  sticky per run: any input element or accumulator was NaN.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mean_out all 64'h0; busy=0; valid=0; nan_flag=0.
  - Internal row/column counters and accumulator cleared.
  - A reset mid-run aborts immediately with no partial output.
- States:
  - IDLE/DONE: start=1 → LOAD. Capture mat into mat_q, clear valid and nan_flag, set busy.
  - LOAD: i=0, j=0, acc=+0.0 → ISSUE.
  - ISSUE: drive adder with a=acc, b=mat_q[i][j] and in_valid=1 for one cycle → WAIT with wcnt=ADD_LAT-1.
  - WAIT:
    - Decrement wcnt each cycle.
    - When the adder out_valid=1, set acc=result and OR isnan(result) into nan_flag.
    - If j==SIZE_B-1 → SCALE, else j++ → ISSUE.
  - SCALE: mean_out[i] = mul_double(acc, INV_B). If i==SIZE_A-1 → DONE, else i++, j=0, acc=+0.0 → ISSUE.
  - DONE: valid=1, busy=0. Remains until start or rst.
- Latency:
  - Each element costs ADD_LAT+1 cycles; each row adds 1 SCALE cycle; LOAD costs 1 cycle.
  - valid rises 1 + SIZE_A·(SIZE_B·(ADD_LAT+1)+1) cycles after the start-accept edge.
  - Defaults give 521 cycles.
- Handshake and corner cases:
  - start while busy is ignored and produces no side effects.
  - start in DONE drops valid on the next cycle and restarts.
  - mat may change after acceptance; only mat_q is used.
- Arithmetic:
  - All values are IEEE-754 binary64 (double); round-to-nearest-even.
  - Accumulation order is fixed: j = 0 → SIZE_B-1.
  - Bench results must be bit-exact against that order.
  - ±Inf propagates per IEEE. A NaN input yields a NaN mean for that row and sets nan_flag.
  - mean_out rows not yet written in the current run keep their previous values, but valid is low during the run.
- The adder out_valid is the only completion source; wcnt is a watchdog for assertion only.
  - out_valid must not arrive before wcnt==0.

Decomposition:
- Shared package fp_double:
  - The double typedef and mul_double (existing).
  - Add: isnan_double function.
  - Add: DOUBLE_ZERO and DOUBLE_ONE constants.
  - Add: the FSM state enum typedef for this block.
- Sub-module double_add_seq (clk, rst, in_valid, a, b, out_valid, result):
  - ADD_LAT-stage pipelined double adder wrapping the vendor FP-add core.
  - A behavioural model is provided for simulation.
  - Instantiated once.

Test Plan:
- All elements 1.0 (64'h3FF0000000000000), start pulse → after 521 cycles valid=1.
  - Every mean_out = 64'h3FF0000000000000; nan_flag=0.
- Row values mat[i][j]=j (0..7) → every mean_out = 3.5 (64'h400C000000000000).
- Row i all −0.5 except row 3 all 2.0:
  - Expected: 64'hBFE0000000000000 for the −0.5 rows.
  - Expected: 64'h4000000000000000 for row 3.
- mat[5][2]=NaN (64'h7FF8000000000000), others 1.0:
  - Expected: mean_out[5] is NaN.
  - Expected: other rows 1.0; nan_flag=1 at valid.
- Second start at cycle 100 of a run → ignored, valid still at cycle 521.
  - Then start in DONE → valid low the next cycle and high again 521 cycles later, with the new data.
- rst asserted at cycle 200 of a run → outputs and flags zero asynchronously, state IDLE.
  - A fresh start then completes correctly with all-ones data.
